commit_trace_buffer: RTL and testbench
======================================

// Module: commit_trace_buffer
// PURPOSE
//   Synthesizable, parametrised replacement for the bench-side register monitor.
//   Snoops the processor's writeback port and captures every retired register write
//   to a watched register into a FIFO: {cycle, rd, data, pc}.
//   Runs for a fixed cycle window after start, then drains and flags done.
//   Sits beside the processor top; a bench or debug port pops entries via valid/ready.
// PARAMETERS
//   XLEN        32            data and PC width
//   REG_AW      5             register address width (2**REG_AW registers)
//   DEPTH       16            FIFO entries; power of two, >= 2
//   WATCH_MASK  32'h0000_006E bit i = 1 -> capture writes to register i (default r1,r2,r3,r5,r6)
//   CYC_W       16            cycle counter / timestamp width
//   RUN_CYCLES  12            capture-window length in clk cycles, 1..2**CYC_W-1
// PORTS
//   clk           in   1       clock, rising edge
//   reset         in   1       asynchronous, active-high
//   start         in   1       one-cycle pulse; arms a capture window
//   wb_rf_enable  in   1       writeback register-file write enable
//   wb_rd         in   REG_AW  writeback destination register
//   wb_data       in   XLEN    writeback data
//   wb_pc         in   XLEN    PC of the retiring instruction
//   rd_ready      in   1       consumer accepts head entry
//   rd_valid      out  1       FIFO not empty
//   rd_cycle      out  CYC_W   head entry timestamp (cycles since start, 0-based)
//   rd_reg        out  REG_AW  head entry register
//   rd_data       out  XLEN    head entry data
//   rd_pc         out  XLEN    head entry PC
//   count         out  $clog2(DEPTH)+1  occupancy
//   overflow      out  1       sticky: at least one capture dropped
//   drop_cnt      out  CYC_W   dropped captures, saturating at all-ones
//   busy          out  1       state is RUN or DRAIN
//   done          out  1       state is DONE
// BEHAVIOUR
//   Reset (async, any time, including mid-window): state=IDLE; pointers, count, cycle
//     counter, overflow, drop_cnt = 0; rd_valid=busy=done=0. FIFO contents are don't-care.
//   FSM states and transitions:
//     IDLE : start -> RUN; cycle counter cleared to 0.
//     RUN  : capture enabled; cycle counter +1 per clk. When counter == RUN_CYCLES-1, the
//            same-edge capture is still taken, then -> DRAIN.
//     DRAIN: capture disabled; when count==0 -> DONE (if the last pop lands this cycle,
//            DONE is entered on the following edge).
//     DONE : done=1; start -> RUN, clearing the cycle counter, overflow and drop_cnt.
//   start is ignored in RUN and DRAIN.
//   Capture condition, sampled at posedge in RUN:
//     wb_rf_enable && wb_rd != 0 && WATCH_MASK[wb_rd].
//     Writes to x0 are never captured, regardless of mask.
//     Entry timestamp is the cycle-counter value before its increment.
//   Push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs on the same edge.
//     Otherwise the capture is dropped: overflow <= 1, drop_cnt +1 (saturating).
//   Pop: rd_valid && rd_ready at posedge.
//     rd_* outputs show the head entry combinationally from the storage array (first-word
//     fall-through). rd_* are don't-care when rd_valid=0.
//   Empty FIFO with push: there is no bypass. rd_valid rises the cycle after the push edge.
//   Pointers are REG'd, $clog2(DEPTH) bits, and wrap naturally modulo DEPTH.
//     count is updated +1, -1 or unchanged for push-only, pop-only, or both/neither.
//   Popping is allowed in every state, including IDLE and DONE after a reset-free restart.
//   Capture-to-visible latency is 1 clk.
// TESTING
//   T1 reset, start, r1<=5 at cycle 0, r3<=7 at cycle 2 (pc 0,8), rd_ready=1
//      -> two pops {0,1,5,0} then {2,3,7,8}; done asserts at cycle 12 + drain; overflow=0.
//   T2 writes to r0, r4, and r7 with rf_enable=1, plus an r2 write with rf_enable=0
//      -> nothing captured; count stays 0.
//   T3 DEPTH=4, rd_ready=0, r1 written on 6 consecutive cycles
//      -> count=4, overflow=1, drop_cnt=2; the 4 oldest entries pop in order.
//   T4 full FIFO with rd_ready=1 and a simultaneous capture
//      -> push accepted, count stays 4, no drop; pointers wrap past DEPTH-1 correctly.
//   T5 assert reset in RUN with 3 entries queued
//      -> immediately state IDLE, rd_valid=0, count=0; a later start resumes from cycle 0.
//   T6 start pulses during RUN and DRAIN are ignored; start in DONE re-arms and clears
//      overflow and drop_cnt.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: snoops the writeback port during a fixed cycle window and
// queues {cycle, rd, data, pc} for watched registers in a first-word fall-through FIFO.
module commit_trace_buffer #(
  parameter int                      XLEN       = 32,
  parameter int                      REG_AW     = 5,
  parameter int                      DEPTH      = 16,
  parameter logic [(2**REG_AW)-1:0]  WATCH_MASK = 'h6E,
  parameter int                      CYC_W      = 16,
  parameter int                      RUN_CYCLES = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      wb_rf_enable,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic [XLEN-1:0]           wb_pc,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [CYC_W-1:0]          rd_cycle,
  output logic [REG_AW-1:0]         rd_reg,
  output logic [XLEN-1:0]           rd_data,
  output logic [XLEN-1:0]           rd_pc,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [CYC_W-1:0]          drop_cnt,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = CYC_W + REG_AW + 2 * XLEN;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(RUN_CYCLES - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [CYC_W-1:0]  drop_q, drop_d;
  logic [EW-1:0]     mem_q [DEPTH];

  logic arm, capture, pop, push, drop;

  // start only re-arms from IDLE or DONE; it is ignored while a window is live.
  assign arm     = start && (state_q == S_IDLE || state_q == S_DONE);
  assign capture = (state_q == S_RUN) && wb_rf_enable && (wb_rd != '0) && WATCH_MASK[wb_rd];
  assign pop     = rd_valid && rd_ready;
  assign push    = capture && ((count_q != FULL_CNT) || pop);
  assign drop    = capture && !push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cyc_q == LAST_CYC) state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    cyc_d      = cyc_q;
    if (arm)                    cyc_d = '0;
    else if (state_q == S_RUN)  cyc_d = cyc_q + CYC_W'(1);
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (arm) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      cyc_q      <= cyc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage holds no reset; only slots between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cyc_q, wb_rd, wb_data, wb_pc};
  end

  assign {rd_cycle, rd_reg, rd_data, rd_pc} = mem_q[rd_ptr_q];
  assign rd_valid  = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed scenarios plus randomized windows, all
// checked against a queue-based reference model of the capture window.
module tb_commit_trace_buffer;

  localparam int XLEN = 32, REG_AW = 5, DEPTH = 4, CYC_W = 16, RUN_CYCLES = 12;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = CYC_W + REG_AW + 2 * XLEN;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk, reset, start, wb_rf_enable, rd_ready;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data, wb_pc;
  logic              rd_valid, overflow, busy, done;
  logic [CYC_W-1:0]  rd_cycle, drop_cnt;
  logic [REG_AW-1:0] rd_reg;
  logic [XLEN-1:0]   rd_data, rd_pc;
  logic [CW-1:0]     count;
  logic [1:0]        dbg_state;
  wire  [W-1:0]      head = {rd_cycle, rd_reg, rd_data, rd_pc};

  commit_trace_buffer #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH),
    .WATCH_MASK(32'h0000_006E), .CYC_W(CYC_W), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .wb_rf_enable(wb_rf_enable),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_cycle(rd_cycle), .rd_reg(rd_reg), .rd_data(rd_data),
    .rd_pc(rd_pc), .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
    .busy(busy), .done(done), .dbg_state(dbg_state));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model: window phase, cycle index, sticky drop info and the entry queue.
  logic [31:0]  watch = 32'h0000_006E;
  int           m_phase, m_cyc, m_drop;
  bit           m_ov;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_phase = P_IDLE; m_cyc = 0; m_drop = 0; m_ov = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int pre = exp_q.size();
    bit pop = rd_ready && (pre > 0);
    bit cap = (m_phase == P_RUN) && wb_rf_enable && (wb_rd != 0) && watch[wb_rd];
    if (pop) void'(exp_q.pop_front());
    if (cap) begin
      if (pre < DEPTH || pop) exp_q.push_back({CYC_W'(m_cyc), wb_rd, wb_data, wb_pc});
      else begin
        m_ov = 1;
        if (m_drop < (1 << CYC_W) - 1) m_drop++;
      end
    end
    case (m_phase)
      P_RUN: begin
        if (m_cyc == RUN_CYCLES - 1) m_phase = P_DRAIN;
        m_cyc++;
      end
      P_DRAIN: if (pre == 0) m_phase = P_DONE;
      default: if (start) begin
        m_phase = P_RUN; m_cyc = 0; m_ov = 0; m_drop = 0;
      end
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic en, input int rd, input int data, input int pc);
    wb_rf_enable = en; wb_rd = REG_AW'(rd); wb_data = XLEN'(data); wb_pc = XLEN'(pc);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) step();
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL wait_done got=%b exp=1", done); end
  endtask

  task automatic drain_check(input string name, input int budget);
    for (int i = 0; i < budget && rd_valid === 1'b1; i++) begin
      n_cmp++;
      if (exp_q.size() == 0 || head !== exp_q[0]) begin
        n_err++; $display("FAIL %s_head got=%h exp=%h (model size %0d)", name, head,
                          exp_q.size() ? exp_q[0] : '0, exp_q.size());
      end
      step();
    end
    n_cmp++;
    if (count !== 0) begin n_err++; $display("FAIL %s_empty got=%0d exp=0", name, count); end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({rd_valid, count, overflow, drop_cnt, busy, done, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset got valid=%b cnt=%0d ov=%b drop=%0d busy=%b done=%b st=%0d exp all 0",
               rd_valid, count, overflow, drop_cnt, busy, done, dbg_state);
    end
  endtask

  task automatic test_basic();
    rd_ready = 1; start = 1; step(); start = 0;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL t1_arm got busy=%b done=%b exp 1/0", busy, done); end
    for (int k = 0; k < RUN_CYCLES; k++) begin
      if (k == 0)      set_wb(1, 1, 5, 0);
      else if (k == 2) set_wb(1, 3, 7, 8);
      else             set_wb(0, 0, 0, 0);
      step();
      if (k == 0 || k == 2) begin
        n_cmp++;
        if (rd_valid !== 1'b1 || head !== (k == 0 ? {16'd0, 5'd1, 32'd5, 32'd0} : {16'd2, 5'd3, 32'd7, 32'd8})) begin
          n_err++; $display("FAIL t1_entry%0d got valid=%b head=%h", k, rd_valid, head);
        end
      end
      if (k == 1) begin
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_err++; $display("FAIL t1_popped got=%b exp=0", rd_valid); end
      end
    end
    set_wb(0, 0, 0, 0);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL t1_drain got busy=%b done=%b exp 1/0", busy, done); end
    step();
    n_cmp++;
    if ({busy, done, overflow} !== 3'b010) begin
      n_err++; $display("FAIL t1_done got busy=%b done=%b ov=%b exp 0/1/0", busy, done, overflow);
    end
  endtask

  task automatic test_filter();
    int rds[4] = '{0, 4, 7, 2};
    start = 1; step(); start = 0; rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_wb(i != 3, rds[i], 32'hA0 + i, 4 * i);
      step();
      n_cmp++;
      if (count !== 0 || rd_valid !== 1'b0) begin
        n_err++; $display("FAIL t2_filter_r%0d got cnt=%0d exp=0", rds[i], count);
      end
    end
    set_wb(0, 0, 0, 0);
    wait_done(30);
  endtask

  task automatic test_overflow();
    start = 1; step(); start = 0; rd_ready = 0;
    for (int i = 0; i < 6; i++) begin set_wb(1, 1, 100 + i, 4 * i); step(); end
    set_wb(0, 0, 0, 0);
    n_cmp++;
    if (count !== 4 || overflow !== 1'b1 || drop_cnt !== 2) begin
      n_err++; $display("FAIL t3_full got cnt=%0d ov=%b drop=%0d exp 4/1/2", count, overflow, drop_cnt);
    end
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (head !== {CYC_W'(i), 5'd1, XLEN'(100 + i), XLEN'(4 * i)}) begin
        n_err++; $display("FAIL t3_order%0d got=%h", i, head);
      end
      step();
    end
    n_cmp++;
    if (count !== 0) begin n_err++; $display("FAIL t3_empty got=%0d exp=0", count); end
    wait_done(30);
  endtask

  task automatic test_back_to_back();
    start = 1; step(); start = 0; rd_ready = 0;
    for (int i = 0; i < 4; i++) begin set_wb(1, 1, 200 + i, i); step(); end
    for (int i = 0; i < 5; i++) begin
      rd_ready = 1; set_wb(1, 2, 300 + i, 16 + i);
      n_cmp++;
      if (head !== exp_q[0]) begin n_err++; $display("FAIL t4_head%0d got=%h exp=%h", i, head, exp_q[0]); end
      step();
      n_cmp++;
      if (count !== 4 || drop_cnt !== 0 || overflow !== 1'b0) begin
        n_err++; $display("FAIL t4_pushpop%0d got cnt=%0d drop=%0d ov=%b exp 4/0/0", i, count, drop_cnt, overflow);
      end
    end
    set_wb(0, 0, 0, 0);
    drain_check("t4", 20);
    wait_done(30);
  endtask

  task automatic test_reset_mid();
    start = 1; step(); start = 0; rd_ready = 0;
    for (int i = 0; i < 3; i++) begin set_wb(1, 3, 40 + i, i); step(); end
    set_wb(0, 0, 0, 0);
    reset = 1; #1;
    model_reset();
    n_cmp++;
    if ({rd_valid, count, busy, done} !== '0) begin
      n_err++; $display("FAIL t5_async got valid=%b cnt=%0d busy=%b done=%b exp all 0", rd_valid, count, busy, done);
    end
    @(posedge clk); #1; reset = 0;
    start = 1; step(); start = 0;
    set_wb(1, 5, 32'h55, 32'h40); step(); set_wb(0, 0, 0, 0);
    n_cmp++;
    if (head !== {16'd0, 5'd5, 32'h55, 32'h40} || count !== 1) begin
      n_err++; $display("FAIL t5_restart got head=%h cnt=%0d", head, count);
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 4; i++) begin set_wb(1, 6, 60 + i, 8 * i); start = (i == 1); step(); end
    start = 0; set_wb(0, 0, 0, 0);
    n_cmp++;
    if (busy !== 1'b1 || overflow !== 1'b1 || drop_cnt !== 1) begin
      n_err++; $display("FAIL t6_run_start got busy=%b ov=%b drop=%0d exp 1/1/1", busy, overflow, drop_cnt);
    end
    for (int i = 0; i < RUN_CYCLES; i++) step();
    start = 1; set_wb(1, 1, 9, 9); step(); start = 0; step(); set_wb(0, 0, 0, 0);
    n_cmp++;
    if ({busy, done} !== 2'b10 || drop_cnt !== 1 || count !== 4) begin
      n_err++; $display("FAIL t6_drain_start got busy=%b done=%b drop=%0d cnt=%0d exp 1/0/1/4", busy, done, drop_cnt, count);
    end
    rd_ready = 1;
    drain_check("t6", 20);
    wait_done(10);
    n_cmp++;
    if (overflow !== 1'b1 || drop_cnt !== 1) begin
      n_err++; $display("FAIL t6_sticky got ov=%b drop=%0d exp 1/1", overflow, drop_cnt);
    end
    start = 1; step(); start = 0;
    n_cmp++;
    if (overflow !== 1'b0 || drop_cnt !== 0 || busy !== 1'b1) begin
      n_err++; $display("FAIL t6_rearm got ov=%b drop=%0d busy=%b exp 0/0/1", overflow, drop_cnt, busy);
    end
    wait_done(40);
  endtask

  task automatic test_random();
    logic [CW+CYC_W+4-1:0] exp_stat, got_stat;
    for (int c = 0; c < 900; c++) begin
      start = (m_phase == P_DONE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      set_wb($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom, $urandom);
      rd_ready = ($urandom_range(0, 2) == 0);
      step();
      exp_stat = {exp_q.size() > 0, CW'(exp_q.size()), m_ov, CYC_W'(m_drop),
                  m_phase == P_RUN || m_phase == P_DRAIN, m_phase == P_DONE};
      got_stat = {rd_valid, count, overflow, drop_cnt, busy, done};
      n_cmp++;
      if (got_stat !== exp_stat) begin
        n_err++; $display("FAIL rand_status c=%0d got=%h exp=%h", c, got_stat, exp_stat);
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        if (head !== exp_q[0]) begin n_err++; $display("FAIL rand_head c=%0d got=%h exp=%h", c, head, exp_q[0]); end
      end
    end
  endtask

  initial begin
    reset = 1; start = 0; rd_ready = 0;
    set_wb(0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1; reset = 0;
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
